// File: rtl/hovalaag_pkg.sv
// hovalaag_pkg
// Shared Hovalaag harness definitions: CPU word width, buffer index width
// and the state encoding of the OUT capture stage.
// Used by the Input, Fifo, Program and Out-capture blocks.
// No ports.

package hovalaag_pkg;

    localparam int WORD_W = 12;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/hovalaag_out_capture_ram.sv
// capture_ram
// 2^ADDR_W x WORD_W synchronous RAM, one write port and one read-first read
// port with a registered output; written to map onto block RAM.
// Ports:
//   clk     in   clock, rising edge
//   rd_clr  in   synchronous clear of the read output register only
//   we      in   write enable
//   waddr   in   write index
//   wdata   in   write data
//   raddr   in   read index
//   rdata   out  registered read data (1-cycle latency)

module capture_ram #(
    parameter int ADDR_W = hovalaag_pkg::ADDR_W,
    parameter int WORD_W = hovalaag_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rd_clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the same edge gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hovalaag_out_capture.sv
// hovalaag_out_capture
// Records every qualified OUT1 write of the Hovalaag CPU, in order, into a
// 2^ADDR_W-entry buffer that the host reads back over EPP. With
// OUT_CAPTURE_COMPARE_EN defined, each captured word is also compared with
// a host-loaded expected sequence; otherwise mismatch/mismatch_idx are 0
// and the exp_* inputs are ignored.
// Ports:
//   clk           in   board clock, rising edge
//   reset         in   synchronous active-high reset
//   clear         in   host clear, same effect as reset
//   cap_strobe    in   one-cycle capture pulse
//   cap_data      in   word to capture
//   rd_addr       in   host read index
//   rd_data       out  captured word at rd_addr, 1-cycle latency
//   count         out  words captured, 0..2^ADDR_W
//   full          out  count == 2^ADDR_W
//   overflow      out  sticky, strobe arrived while full
//   exp_set       in   write expected word
//   exp_addr      in   expected-word index
//   exp_data      in   expected word
//   mismatch      out  sticky, a compare failed
//   mismatch_idx  out  index of first failing word
//
// state   | meaning
// EMPTY   | count = 0
// FILLING | 0 < count < 2^ADDR_W
// FULL    | count = 2^ADDR_W, further strobes dropped and flagged

module hovalaag_out_capture
    import hovalaag_pkg::*;
#(
    parameter int ADDR_W = hovalaag_pkg::ADDR_W,
    parameter int WORD_W = hovalaag_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              cap_strobe,
    input  logic [WORD_W-1:0] cap_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    input  logic              exp_set,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [WORD_W-1:0] exp_data,
    output logic              mismatch,
    output logic [ADDR_W-1:0] mismatch_idx
);

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(2**ADDR_W - 1);

    cap_state_t        state;
    logic              clr;
    logic              capture;
    logic [ADDR_W-1:0] wr_idx;

    // Clear beats a coincident strobe: the strobe is simply discarded.
    assign clr     = reset | clear;
    assign capture = cap_strobe & (state != FULL) & ~clr;
    assign wr_idx  = count[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= EMPTY;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else if (cap_strobe) begin
            if (state == FULL) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
                if (count == LAST) begin
                    state <= FULL;
                    full  <= 1'b1;
                end else begin
                    state <= FILLING;
                end
            end
        end
    end

    capture_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_cap_ram (
        .clk    (clk),
        .rd_clr (clr),
        .we     (capture),
        .waddr  (wr_idx),
        .wdata  (cap_data),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

`ifdef OUT_CAPTURE_COMPARE_EN
    logic [WORD_W-1:0] exp_q;
    logic [WORD_W-1:0] cap_q;
    logic [ADDR_W-1:0] idx_q;
    logic              cmp_valid;

    // Expected word is fetched at the capture index on the capture edge,
    // so it lines up with the delayed capture word one cycle later.
    capture_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_exp_ram (
        .clk    (clk),
        .rd_clr (clr),
        .we     (exp_set),
        .waddr  (exp_addr),
        .wdata  (exp_data),
        .raddr  (wr_idx),
        .rdata  (exp_q)
    );

    always_ff @(posedge clk) begin
        cap_q <= cap_data;
        idx_q <= wr_idx;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cmp_valid    <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
        end else begin
            cmp_valid <= capture;
            if (cmp_valid && (cap_q != exp_q)) begin
                mismatch <= 1'b1;
                if (!mismatch) begin
                    mismatch_idx <= idx_q;
                end
            end
        end
    end
`else
    logic unused_exp;
    assign unused_exp   = ^{exp_set, exp_addr, exp_data};
    assign mismatch     = 1'b0;
    assign mismatch_idx = '0;
`endif

endmodule

// File: tb/tb_hovalaag_out_capture.sv
module tb_hovalaag_out_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        cap_strobe = 1'b0;
    logic [11:0] cap_data = '0;
    logic [7:0]  rd_addr = '0;
    logic [11:0] rd_data;
    logic [8:0]  count;
    logic        full;
    logic        overflow;
    logic        exp_set = 1'b0;
    logic [7:0]  exp_addr = '0;
    logic [11:0] exp_data = '0;
    logic        mismatch;
    logic [7:0]  mismatch_idx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hovalaag_out_capture dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .cap_strobe   (cap_strobe),
        .cap_data     (cap_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .exp_set      (exp_set),
        .exp_addr     (exp_addr),
        .exp_data     (exp_data),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx)
    );

`ifdef OUT_CAPTURE_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [11:0] d);
        cap_strobe = 1'b1;
        cap_data   = d;
        tick();
        cap_strobe = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // reset values
        tick(); tick();
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_mismatch_idx", 32'(mismatch_idx), 32'd0);
        reset = 1'b0;
        tick();

        // fill and read back
        strobe(12'h001);
        check("fill_count1", 32'(count), 32'd1);
        strobe(12'hABC);
        strobe(12'hFFF);
        check("fill_count3", 32'(count), 32'd3);
        check("fill_full", 32'(full), 32'd0);
        rd_addr = 8'd0; tick();
        check("fill_rd0", 32'(rd_data), 32'h001);
        rd_addr = 8'd1; tick();
        check("fill_rd1", 32'(rd_data), 32'hABC);
        rd_addr = 8'd2; tick();
        check("fill_rd2", 32'(rd_data), 32'hFFF);

        // clear versus strobe after 5 captures
        strobe(12'h0D3);
        strobe(12'h0D4);
        check("clr_pre_count", 32'(count), 32'd5);
        clear = 1'b1; cap_strobe = 1'b1; cap_data = 12'h123;
        tick();
        clear = 1'b0; cap_strobe = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);
        strobe(12'h0A0);
        check("clr_next_count", 32'(count), 32'd1);
        rd_addr = 8'd0; tick();
        check("clr_next_idx0", 32'(rd_data), 32'h0A0);
        rd_addr = 8'd1; tick();
        check("clr_keeps_idx1", 32'(rd_data), 32'hABC);

        // read-during-write at index 4
        strobe(12'h0A1);
        strobe(12'h0A2);
        strobe(12'h0A3);
        check("rdw_pre_count", 32'(count), 32'd4);
        rd_addr = 8'd4; cap_strobe = 1'b1; cap_data = 12'h777;
        tick();
        cap_strobe = 1'b0;
        check("rdw_old", 32'(rd_data), 32'h0D4);
        tick();
        check("rdw_new", 32'(rd_data), 32'h777);
        check("rdw_count", 32'(count), 32'd5);

        // compare: expected 10,20,30,40 vs captures 10,20,31,41
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            exp_set  = 1'b1;
            exp_addr = 8'(i);
            exp_data = 12'(10 * (i + 1));
            tick();
        end
        exp_set = 1'b0;
        check("exp_set_count", 32'(count), 32'd0);
        check("exp_set_mismatch", 32'(mismatch), 32'd0);
        strobe(12'd10);
        strobe(12'd20);
        strobe(12'd31);
        check("cmp_not_yet", 32'(mismatch), 32'd0);
        strobe(12'd41);
        check("cmp_mismatch", 32'(mismatch), 32'(CMP));
        check("cmp_idx", 32'(mismatch_idx), CMP ? 32'd2 : 32'd0);
        tick();
        check("cmp_sticky", 32'(mismatch), 32'(CMP));
        check("cmp_idx_held", 32'(mismatch_idx), CMP ? 32'd2 : 32'd0);

        // clear while a failing compare is in flight
        pulse_clear();
        check("cancel_cleared", 32'(mismatch), 32'd0);
        strobe(12'd5);
        pulse_clear();
        tick();
        check("cancel_mismatch", 32'(mismatch), 32'd0);

        // full and overflow
        pulse_clear();
        for (int i = 0; i < 255; i++) strobe(12'(i));
        check("full_count255", 32'(count), 32'd255);
        check("full_not_yet", 32'(full), 32'd0);
        strobe(12'd255);
        check("full_count256", 32'(count), 32'd256);
        check("full_flag", 32'(full), 32'd1);
        check("full_no_ovf", 32'(overflow), 32'd0);
        strobe(12'h555);
        check("ovf_count", 32'(count), 32'd256);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_full", 32'(full), 32'd1);
        rd_addr = 8'd0; tick();
        check("ovf_rd0", 32'(rd_data), 32'h000);
        rd_addr = 8'd255; tick();
        check("ovf_rd255", 32'(rd_data), 32'h0FF);
        check("full_cmp_idx", 32'(mismatch_idx), 32'd0);
        check("full_cmp_mismatch", 32'(mismatch), 32'(CMP));

        // reset mid-run
        pulse_clear();
        for (int i = 0; i < 100; i++) strobe(12'(12'h100 + i));
        tick(); tick();
        check("mid_count", 32'(count), 32'd100);
        check("mid_mismatch", 32'(mismatch), 32'(CMP));
        reset = 1'b1; rd_addr = 8'd0;
        tick();
        check("mid_rst_rd_data", 32'(rd_data), 32'h0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_mismatch", 32'(mismatch), 32'd0);
        check("mid_rst_idx", 32'(mismatch_idx), 32'd0);
        reset = 1'b0;
        tick();
        check("mid_keep_idx0", 32'(rd_data), 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hovalaag_out_capture.md
# hovalaag_out_capture

Output capture stage directly downstream of the Hovalaag CPU's OUT port in the board harness. Each qualified OUT1 write, one pulse per CPU step, is recorded in order into a 256-entry buffer. The host reads the buffer back over the EPP interface, so a whole run's output can be checked instead of only the last value on the seven-segment display. An optional compare engine checks each captured word against an expected sequence loaded by the host.

## Interface

Parameters:
- ADDR_W, 8: buffer index width; depth = 2^ADDR_W.
- WORD_W, 12: CPU word width.

Ports:
- clk  in  1  board clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  host clear; same effect as reset on this block.
- cap_strobe  in  1  one-cycle capture pulse (OUT_valid & !OUT_select & do_hoval_IO).
- cap_data  in  WORD_W  OUT value to capture.
- rd_addr  in  ADDR_W  host read index.
- rd_data  out  WORD_W  captured word at rd_addr.
- count  out  ADDR_W+1  number of words captured, 0..256.
- full  out  1  count == 256.
- overflow  out  1  sticky; a strobe arrived while full.
- exp_set  in  1  write expected word (compare build only).
- exp_addr  in  ADDR_W  expected-word index.
- exp_data  in  WORD_W  expected word.
- mismatch  out  1  sticky; a compare failed.
- mismatch_idx  out  ADDR_W  index of the first failing word.

## Operation

- State machine has three states:
  - EMPTY: count = 0.
  - FILLING: 0 < count < 256.
  - FULL: count = 256.
- Transitions:
  - EMPTY→FILLING on the first strobe.
  - FILLING→FULL on the strobe that makes count = 256.
  - Any state→EMPTY on reset or clear.
- Capture: on a strobe when not FULL:
  - write cap_data at index count[ADDR_W-1:0];
  - increment count.
- Strobe in FULL: data is dropped, count is held, overflow is set.
- reset or clear asserted in the same cycle as a strobe: clear wins and the strobe is discarded.
- reset or clear zeroes count, overflow, mismatch and mismatch_idx. Buffer and expected RAM contents are not cleared.
- Reads are read-first. A read of the index being written in the same cycle returns the old contents.
- Compare (compare build only): a capture at index i reads expected[i].
  - The compare happens one cycle later.
  - On inequality, mismatch is set. mismatch_idx latches i only if mismatch was 0 beforehand.
  - A strobe dropped in FULL is not compared.
- exp_set writes expected[exp_addr] at any time. It does not alter count or the flags.

## Timing

- Reset values: rd_data = 0, count = 0, full = 0, overflow = 0, mismatch = 0, mismatch_idx = 0.
- rd_data: registered, 1-cycle latency from rd_addr.
- count, full, overflow: update on the cycle after the strobe edge.
- mismatch, mismatch_idx: update 2 cycles after the strobe. The pipeline is write/read expected, then compare.
- Back-to-back strobes on consecutive cycles are supported at full rate, with a fully pipelined compare.
- A clear during a compare in flight cancels it; mismatch stays 0.

## Configuration

- OUT_CAPTURE_COMPARE_EN defined:
  - expected RAM and compare pipeline are built;
  - exp_set, exp_addr and exp_data are honoured.
- Not defined:
  - no expected RAM;
  - exp_* inputs are ignored;
  - mismatch and mismatch_idx are tied to 0.

## Structure

- Shared package hovalaag_pkg holds:
  - WORD_W = 12 and ADDR_W = 8, also used by Input, Fifo and Program;
  - the capture state encoding: EMPTY, FILLING, FULL.
- Sub-module capture_ram: a 2^ADDR_W × WORD_W synchronous RAM with one write port and one read-first read port. It maps to block RAM.
  - Instantiated once for captured data.
  - Instantiated a second time for expected data under OUT_CAPTURE_COMPARE_EN.

## Test plan

- Fill and read back:
  - Stimulus: strobe 0x001, 0xABC, 0xFFF on consecutive cycles, then read indices 0..2.
  - Response: count = 3; rd_data returns 0x001, 0xABC, 0xFFF, each one cycle after its address.
- Full and overflow:
  - Stimulus: 256 strobes with data = index, then a 257th strobe with data 0x555.
  - Response: full = 1, count = 256, overflow = 1, index 0 still reads 0x000.
- Clear versus strobe:
  - Stimulus: clear and strobe 0x123 asserted in the same cycle, after 5 prior captures.
  - Response: count = 0, overflow = 0. The next strobe writes index 0.
- Read-during-write:
  - Stimulus: rd_addr = 4 while the 5th strobe writes 0x777 at index 4.
  - Response: rd_data returns the old value; the next read returns 0x777.
- Compare (EN defined):
  - Stimulus: expected = 10, 20, 30, 40; captures 10, 20, 31, 41.
  - Response: mismatch rises 2 cycles after the third strobe; mismatch_idx = 2, which stays unchanged after the fourth strobe.
- Reset mid-run:
  - Stimulus: reset asserted after 100 captures with mismatch set.
  - Response: all outputs return to reset values. Index 0 still reads its previously captured word.
